// File: rtl/game_move_ctrl.sv
// Player-movement controller: debounced buttons drive a clamped sprite position updated once per frame.
// Optional build macro MOVE_ACCEL_EN enables hold-to-accelerate (double step after HOLD_FRAMES moving frames).
module game_move_ctrl #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 16,
    parameter int STEP       = 2,
    parameter int START_X    = 312,
    parameter int START_Y    = 232,
    parameter int DEB_CYCLES = 250000
`ifdef MOVE_ACCEL_EN
    ,
    parameter int HOLD_FRAMES = 30
`endif
) (
    input  logic       dclk,
    input  logic       rst_n,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       frame_tick,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       pos_valid,
    output logic       moving,
    output logic [3:0] btn_state
);

    localparam int          CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [10:0] X_MAX    = 11'(H_RES - SPRITE_W);
    localparam logic [10:0] Y_MAX    = 11'(V_RES - SPRITE_H);

    typedef enum logic [1:0] {IDLE, SAMPLE, UPDATE, PUBLISH} state_t;

    state_t        state_r, state_s;
    logic [3:0]    btn_raw_s;
    logic [3:0]    sync1_r, sync2_r, deb_r;
    logic [CW-1:0] cnt_r [4];
    logic [3:0]    dir_r;
    logic [9:0]    player_x_r, player_y_r;
    logic          pos_valid_r, moving_r;
    logic [10:0]   step_s, x_cur_s, y_cur_s, nx_s, ny_s;

    assign btn_raw_s = {btnUp, btnDown, btnLeft, btnRight};

    // Two-flop synchronisers for the asynchronous buttons
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-button debounce: level flips only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r <= 4'b0000;
            for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_LAST) begin
                    deb_r[i] <= sync2_r[i];
                    cnt_r[i] <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // FSM next-state logic; ticks outside IDLE are dropped
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (frame_tick) state_s = SAMPLE; else state_s = IDLE;
            SAMPLE:  state_s = UPDATE;
            UPDATE:  state_s = PUBLISH;
            PUBLISH: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

`ifdef MOVE_ACCEL_EN
    logic [5:0] hold_r;
    logic [3:0] prev_dir_r;

    assign step_s = ({26'd0, hold_r} >= 32'(HOLD_FRAMES)) ? 11'(2 * STEP) : 11'(STEP);

    // Hold counter: the count includes the current frame, so a new direction starts at one
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r     <= 6'd0;
            prev_dir_r <= 4'b0000;
        end else if (state_r == PUBLISH) begin
            prev_dir_r <= dir_r;
            if (!moving_r)               hold_r <= 6'd0;
            else if (dir_r != prev_dir_r) hold_r <= 6'd1;
            else if (hold_r != 6'd63)    hold_r <= hold_r + 6'd1;
            else                         hold_r <= hold_r;
        end
    end
`else
    assign step_s = 11'(STEP);
`endif

    // Clamped next position in 11 bits so neither edge can wrap
    always_comb begin
        x_cur_s = {1'b0, player_x_r};
        y_cur_s = {1'b0, player_y_r};
        nx_s    = x_cur_s;
        ny_s    = y_cur_s;
        if (dir_r[1]) begin
            if (x_cur_s < step_s) nx_s = 11'd0;
            else                  nx_s = x_cur_s - step_s;
        end else if (dir_r[0]) begin
            if (x_cur_s + step_s > X_MAX) nx_s = X_MAX;
            else                          nx_s = x_cur_s + step_s;
        end else begin
            nx_s = x_cur_s;
        end
        if (dir_r[3]) begin
            if (y_cur_s < step_s) ny_s = 11'd0;
            else                  ny_s = y_cur_s - step_s;
        end else if (dir_r[2]) begin
            if (y_cur_s + step_s > Y_MAX) ny_s = Y_MAX;
            else                          ny_s = y_cur_s + step_s;
        end else begin
            ny_s = y_cur_s;
        end
    end

    // Direction latch, position update and publish flags
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            dir_r       <= 4'b0000;
            player_x_r  <= 10'(START_X);
            player_y_r  <= 10'(START_Y);
            pos_valid_r <= 1'b0;
            moving_r    <= 1'b0;
        end else begin
            pos_valid_r <= (state_r == UPDATE);
            if (state_r == SAMPLE) begin
                dir_r <= {deb_r[3] & ~deb_r[2], deb_r[2] & ~deb_r[3],
                          deb_r[1] & ~deb_r[0], deb_r[0] & ~deb_r[1]};
            end
            if (state_r == UPDATE) begin
                player_x_r <= nx_s[9:0];
                player_y_r <= ny_s[9:0];
                moving_r   <= (nx_s != x_cur_s) || (ny_s != y_cur_s);
            end
        end
    end

    assign player_x  = player_x_r;
    assign player_y  = player_y_r;
    assign pos_valid = pos_valid_r;
    assign moving    = moving_r;
    assign btn_state = deb_r;

endmodule

// File: tb/tb_game_move_ctrl.sv
// Directed bench for game_move_ctrl: table of frame moves plus debounce, clamp, overrun, reset and acceleration sequences.
module tb_game_move_ctrl;

    logic       dclk;
    logic       rst_n;
    logic [3:0] b  [3];
    logic       ft [3];
    logic [9:0] px [3];
    logic [9:0] py [3];
    logic       pv [3];
    logic       mv [3];
    logic [3:0] bs [3];

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [3:0] btn;
        int         ex;
        int         ey;
        logic       em;
    } vec_t;
    vec_t vecs [8];

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    game_move_ctrl #(.DEB_CYCLES(4)) u_dut (
        .dclk(dclk), .rst_n(rst_n),
        .btnUp(b[0][3]), .btnDown(b[0][2]), .btnLeft(b[0][1]), .btnRight(b[0][0]),
        .frame_tick(ft[0]), .player_x(px[0]), .player_y(py[0]),
        .pos_valid(pv[0]), .moving(mv[0]), .btn_state(bs[0])
    );

    game_move_ctrl #(.DEB_CYCLES(4), .START_X(623), .START_Y(1)) u_clamp (
        .dclk(dclk), .rst_n(rst_n),
        .btnUp(b[1][3]), .btnDown(b[1][2]), .btnLeft(b[1][1]), .btnRight(b[1][0]),
        .frame_tick(ft[1]), .player_x(px[1]), .player_y(py[1]),
        .pos_valid(pv[1]), .moving(mv[1]), .btn_state(bs[1])
    );

`ifdef MOVE_ACCEL_EN
    game_move_ctrl #(.DEB_CYCLES(4), .START_X(300), .HOLD_FRAMES(3)) u_acc (
        .dclk(dclk), .rst_n(rst_n),
        .btnUp(b[2][3]), .btnDown(b[2][2]), .btnLeft(b[2][1]), .btnRight(b[2][0]),
        .frame_tick(ft[2]), .player_x(px[2]), .player_y(py[2]),
        .pos_valid(pv[2]), .moving(mv[2]), .btn_state(bs[2])
    );
`else
    assign px[2] = 10'd0;
    assign py[2] = 10'd0;
    assign pv[2] = 1'b0;
    assign mv[2] = 1'b0;
    assign bs[2] = 4'd0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_btn(input int sel, input logic [3:0] val);
        @(negedge dclk) b[sel] = val;
        repeat (8) @(negedge dclk);
        check($sformatf("btn_state_%0d", sel), 32'(bs[sel]), 32'(val));
    endtask

    // Tick at cycle T; position and pos_valid expected during T+3 only
    task automatic run_frame(input int sel, input int ex, input int ey, input logic em, input string nm);
        @(negedge dclk) ft[sel] = 1'b1;
        @(negedge dclk) ft[sel] = 1'b0;
        check({nm, "_pv_t1"}, 32'(pv[sel]), 32'd0);
        @(negedge dclk);
        check({nm, "_pv_t2"}, 32'(pv[sel]), 32'd0);
        @(negedge dclk);
        check({nm, "_pv_t3"}, 32'(pv[sel]), 32'd1);
        check({nm, "_x"}, 32'(px[sel]), 32'(ex));
        check({nm, "_y"}, 32'(py[sel]), 32'(ey));
        check({nm, "_moving"}, 32'(mv[sel]), 32'(em));
        @(negedge dclk);
        check({nm, "_pv_t4"}, 32'(pv[sel]), 32'd0);
    endtask

    initial begin
        int pulses;
        vecs[0] = '{4'b0001, 314, 232, 1'b1};
        vecs[1] = '{4'b0101, 316, 234, 1'b1};
        vecs[2] = '{4'b1100, 316, 234, 1'b0};
        vecs[3] = '{4'b0011, 316, 234, 1'b0};
        vecs[4] = '{4'b1010, 314, 232, 1'b1};
        vecs[5] = '{4'b0000, 314, 232, 1'b0};
        vecs[6] = '{4'b1110, 312, 232, 1'b1};
        vecs[7] = '{4'b0010, 310, 232, 1'b1};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b[i]  = 4'b0000;
            ft[i] = 1'b0;
        end
        repeat (3) @(negedge dclk);
        rst_n = 1'b1;
        repeat (5) @(negedge dclk);
        check("rst_x", 32'(px[0]), 32'd312);
        check("rst_y", 32'(py[0]), 32'd232);
        check("rst_pv", 32'(pv[0]), 32'd0);
        check("rst_moving", 32'(mv[0]), 32'd0);
        check("rst_btn", 32'(bs[0]), 32'd0);

        // Three-cycle glitch must be rejected
        @(negedge dclk) b[0] = 4'b0001;
        repeat (3) @(negedge dclk);
        b[0] = 4'b0000;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge dclk);
            if (bs[0] != 4'b0000) pulses++;
        end
        check("glitch_rejected", 32'(pulses), 32'd0);

        // Held press accepted exactly six edges after assertion
        @(negedge dclk) b[0] = 4'b0001;
        repeat (5) @(negedge dclk);
        check("deb_edge5", 32'(bs[0]), 32'd0);
        @(negedge dclk);
        check("deb_edge6", 32'(bs[0]), 32'd1);
        set_btn(0, 4'b0000);

        for (int i = 0; i < 8; i++) begin
            set_btn(0, vecs[i].btn);
            run_frame(0, vecs[i].ex, vecs[i].ey, vecs[i].em, $sformatf("vec%0d", i));
        end

        // Right edge and top edge clamp, diagonal
        set_btn(1, 4'b1001);
        run_frame(1, 624, 0, 1'b1, "clamp1");
        run_frame(1, 624, 0, 1'b0, "clamp2");

`ifdef MOVE_ACCEL_EN
        set_btn(2, 4'b0010);
        run_frame(2, 298, 232, 1'b1, "acc1");
        run_frame(2, 296, 232, 1'b1, "acc2");
        run_frame(2, 294, 232, 1'b1, "acc3");
        run_frame(2, 290, 232, 1'b1, "acc4");
        run_frame(2, 286, 232, 1'b1, "acc5");
`endif

        // Second tick one cycle later is ignored
        set_btn(0, 4'b0001);
        @(negedge dclk) ft[0] = 1'b1;
        @(negedge dclk) ft[0] = 1'b1;
        @(negedge dclk) ft[0] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge dclk);
            if (pv[0]) pulses++;
        end
        check("overrun_pulses", 32'(pulses), 32'd1);
        check("overrun_x", 32'(px[0]), 32'd312);

        // Reset during UPDATE aborts the frame
        @(negedge dclk) ft[0] = 1'b1;
        @(negedge dclk) ft[0] = 1'b0;
        @(negedge dclk);
        rst_n = 1'b0;
        #1;
        check("midrst_x", 32'(px[0]), 32'd312);
        check("midrst_y", 32'(py[0]), 32'd232);
        check("midrst_btn", 32'(bs[0]), 32'd0);
        check("midrst_moving", 32'(mv[0]), 32'd0);
        repeat (3) @(negedge dclk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge dclk);
            if (pv[0]) pulses++;
        end
        check("midrst_no_pv", 32'(pulses), 32'd0);
        check("midrst_x_after", 32'(px[0]), 32'd312);
        check("midrst_clamp_x", 32'(px[1]), 32'd623);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
